// File: rtl/xswitch_pkg.sv
// Shared types and constants for the switch arbitration blocks.
// Provides the arbiter state encoding, the packet counter width and a
// modulo-N increment helper used for round-robin pointer updates.
package xswitch_pkg;

    // Arbiter FSM states: ARB searches for a new grant, LOCK holds one input
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Width of each per-input completed-packet counter
    localparam int PKT_CNT_W = 16;

    // Increment an index modulo n (n need not be a power of two)
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xrr_pick.sv
// Combinational round-robin picker.
// Returns the first requesting index found when searching ptr, ptr+1, ...
// wrapping modulo N_IN. Works for non-power-of-two N_IN: every candidate
// index is folded back into 0..N_IN-1, so no out-of-range request bit is
// ever sampled. When nothing requests, idx echoes ptr and any is low.
module xrr_pick #(
    parameter  int N_IN  = 4,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // N_IN always fits in IDX_W+1 bits, as does ptr + offset
    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_IN);

    logic [IDX_W:0]   w_sum  [N_IN];
    logic [IDX_W-1:0] w_cand [N_IN];
    logic [N_IN-1:0]  w_hit;

    // Candidate index for each search offset, folded back into range
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, ptr} + (IDX_W + 1)'(gi);
            assign w_cand[gi] = (w_sum[gi] >= N_LIM) ? IDX_W'(w_sum[gi] - N_LIM)
                                                     : IDX_W'(w_sum[gi]);
            assign w_hit[gi]  = req[w_cand[gi]];
        end
    endgenerate

    // Priority select: the smallest search offset with a request wins
    always_comb begin
        any = 1'b0;
        idx = ptr;
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                any = 1'b1;
                idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/xarb_mux.sv
// Packet-aware round-robin arbiter and stream multiplexer.
// Merges N_IN valid/ready/data/last streams into one output stream with a
// purely combinational datapath; the downstream register slice retimes it.
// Once an input wins, it keeps the output until its last beat is accepted,
// and a stalled first beat also freezes the grant so the output is stable.
// Optional feature: define XARB_PKT_CNT_EN to add the pkt_cnt output with
// one wrapping 16-bit completed-packet counter per input.
module xarb_mux
    import xswitch_pkg::*;
#(
    parameter  int N_IN    = 4,
    parameter  int D_WIDTH = 16,
    localparam int IDX_W   = $clog2(N_IN)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_IN-1:0]           vldi,
    input  logic [N_IN-1:0]           lasti,
    input  logic [N_IN*D_WIDTH-1:0]   datai,
    output logic [N_IN-1:0]           rdyi,
    output logic                      vldo,
    output logic                      lasto,
    output logic [D_WIDTH-1:0]        datao,
    input  logic                      rdyo,
`ifdef XARB_PKT_CNT_EN
    output logic [N_IN*PKT_CNT_W-1:0] pkt_cnt,
`endif
    output logic [IDX_W-1:0]          gnt_idx
);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_lock_next;

    logic             w_pick_any;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_vld;
    logic             w_sel_last;
    logic             w_xfer;
    logic [D_WIDTH-1:0] w_data_arr [N_IN];

    // Unpack the flat data bus into one lane per input
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
            assign w_data_arr[gi] = datai[gi*D_WIDTH +: D_WIDTH];
        end
    endgenerate

    xrr_pick #(
        .N_IN (N_IN)
    ) u_pick (
        .req (vldi),
        .ptr (r_ptr),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    // In LOCK only the locked input is looked at; other requests are ignored
    assign w_sel_idx  = (r_state == LOCK) ? r_lock_idx : w_pick_idx;
    assign w_sel_vld  = (r_state == LOCK) ? vldi[r_lock_idx] : w_pick_any;
    assign w_sel_last = lasti[w_sel_idx];
    assign w_xfer     = rstn & w_sel_vld & rdyo;

    // State register: arbitration state, round-robin pointer and locked index
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ARB;
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_lock_idx <= w_lock_next;
        end
    end

    // Next-state logic: lock on a multi-beat start or a stalled beat,
    // advance the pointer past the winner when a packet completes
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_lock_next  = r_lock_idx;
        case (r_state)
            ARB: begin
                if (w_pick_any) begin
                    if (rdyo && w_sel_last) begin
                        w_ptr_next = IDX_W'(wrap_inc(int'(w_pick_idx), N_IN));
                    end else begin
                        w_state_next = LOCK;
                        w_lock_next  = w_pick_idx;
                    end
                end
            end
            LOCK: begin
                if (w_xfer && w_sel_last) begin
                    w_state_next = ARB;
                    w_ptr_next   = IDX_W'(wrap_inc(int'(r_lock_idx), N_IN));
                end
            end
            default: begin
                w_state_next = ARB;
            end
        endcase
    end

    // Output logic: pass the selected lane through, everything low in reset
    always_comb begin
        vldo    = 1'b0;
        lasto   = 1'b0;
        datao   = '0;
        gnt_idx = '0;
        rdyi    = '0;
        if (rstn) begin
            vldo    = w_sel_vld;
            lasto   = w_sel_vld & w_sel_last;
            datao   = w_data_arr[w_sel_idx];
            gnt_idx = w_sel_idx;
            if (w_sel_vld && rdyo) begin
                rdyi[w_sel_idx] = 1'b1;
            end
        end
    end

`ifdef XARB_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] r_pkt_cnt [N_IN];

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_cnt
            // Count packets whose last beat was accepted from this input
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_pkt_cnt[gi] <= '0;
                end else if (w_xfer && w_sel_last && (w_sel_idx == IDX_W'(gi))) begin
                    r_pkt_cnt[gi] <= r_pkt_cnt[gi] + PKT_CNT_W'(1);
                end
            end
            assign pkt_cnt[gi*PKT_CNT_W +: PKT_CNT_W] = rstn ? r_pkt_cnt[gi] : '0;
        end
    endgenerate
`else
    // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_xarb_mux.sv
// Scoreboard bench for xarb_mux: per-input source queues drive the inputs,
// directed tests push the hand-ordered expected beats, and a monitor pops
// and compares on every accepted output beat.
module tb_xarb_mux;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk   = 1'b0;
    logic            rstn  = 1'b0;
    logic [N-1:0]    vldi  = '0;
    logic [N-1:0]    lasti = '0;
    logic [N*DW-1:0] datai = '0;
    logic [N-1:0]    rdyi;
    logic            vldo;
    logic            lasto;
    logic [DW-1:0]   datao;
    logic            rdyo  = 1'b1;
    logic [1:0]      gnt_idx;
`ifdef XARB_PKT_CNT_EN
    logic [N*16-1:0] pkt_cnt;
`endif

    xarb_mux #(.N_IN(N), .D_WIDTH(DW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .vldi    (vldi),
        .lasti   (lasti),
        .datai   (datai),
        .rdyi    (rdyi),
        .vldo    (vldo),
        .lasto   (lasto),
        .datao   (datao),
        .rdyo    (rdyo),
`ifdef XARB_PKT_CNT_EN
        .pkt_cnt (pkt_cnt),
`endif
        .gnt_idx (gnt_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        last;
        logic        bubble;
    } beat_t;

    typedef struct {
        logic [15:0] d;
        logic        last;
        int          idx;
    } exp_t;

    beat_t src_q [N][$];
    exp_t  exp_q [$];
    int    checks = 0;
    int    errors = 0;
    int    model_cnt [N] = '{default: 0};
    bit    quiet = 1'b0;
    exp_t  mon_e;
    logic [N-1:0] drv_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int i, input logic [15:0] d, input logic last);
        beat_t b;
        b.d = d; b.last = last; b.bubble = 1'b0;
        src_q[i].push_back(b);
    endtask

    task automatic push_bubble(input int i);
        beat_t b;
        b.d = '0; b.last = 1'b0; b.bubble = 1'b1;
        src_q[i].push_back(b);
    endtask

    task automatic push_exp(input logic [15:0] d, input logic last, input int idx);
        exp_t e;
        e.d = d; e.last = last; e.idx = idx;
        exp_q.push_back(e);
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0 || src_busy()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
            for (int i = 0; i < N; i++) src_q[i].delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Source driver: retire accepted beats and one-cycle bubbles, present heads
    initial begin
        beat_t tmp;
        forever begin
            @(negedge clk);
            drv_acc = vldi & rdyi;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() != 0) begin
                    if (drv_acc[i]) tmp = src_q[i].pop_front();
                    else if (!vldi[i] && src_q[i][0].bubble) tmp = src_q[i].pop_front();
                end
                if (src_q[i].size() == 0 || src_q[i][0].bubble) begin
                    vldi[i]  = 1'b0;
                    lasti[i] = 1'b0;
                end else begin
                    vldi[i]            = 1'b1;
                    lasti[i]           = src_q[i][0].last;
                    datai[i*DW +: DW]  = src_q[i][0].d;
                end
            end
        end
    end

    // Monitor: every accepted output beat is compared with the scoreboard head
    always @(negedge clk) begin
        if (rstn && vldo && rdyo) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%0h idx %0d, required no beat", datao, gnt_idx);
            end else begin
                mon_e = exp_q.pop_front();
                chk("datao", 32'(datao), 32'(mon_e.d));
                chk("lasto", 32'(lasto), 32'(mon_e.last));
                chk("gnt_idx", 32'(gnt_idx), 32'(mon_e.idx));
                chk("rdyi_onehot", 32'(rdyi), 32'(1) << mon_e.idx);
                if (mon_e.last) model_cnt[mon_e.idx]++;
                if (!quiet) $display("beat: idx=%0d data=0x%04h last=%0b", gnt_idx, datao, lasto);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin stimulus is loaded during reset; outputs must stay low
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                push_beat(i, 16'hA000 + 16'(r * 16 + i), 1'b1);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                push_exp(16'hA000 + 16'(r * 16 + i), 1'b1, i);
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk("reset_vldo", 32'(vldo), 0);
            chk("reset_rdyi", 32'(rdyi), 0);
            chk("reset_gnt_idx", 32'(gnt_idx), 0);
            chk("reset_lasto", 32'(lasto), 0);
            chk("reset_datao", 32'(datao), 0);
        end
        @(posedge clk);
        #2 rstn = 1'b1;
        drain("round_robin", 100);

        // Packet lock: in0 three beats, in1 waits its turn
        push_beat(0, 16'hB000, 1'b0);
        push_beat(0, 16'hB001, 1'b0);
        push_beat(0, 16'hB002, 1'b1);
        push_beat(1, 16'hC000, 1'b1);
        push_exp(16'hB000, 1'b0, 0);
        push_exp(16'hB001, 1'b0, 0);
        push_exp(16'hB002, 1'b1, 0);
        push_exp(16'hC000, 1'b1, 1);
        drain("packet_lock", 100);

        // Stall: in2 held for 5 cycles, in1 arrives mid-stall
        @(posedge clk);
        #2 rdyo = 1'b0;
        push_beat(2, 16'h1234, 1'b1);
        push_exp(16'h1234, 1'b1, 2);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_vldo", 32'(vldo), 1);
            chk("stall_datao", 32'(datao), 32'h1234);
            chk("stall_gnt_idx", 32'(gnt_idx), 2);
            chk("stall_rdyi", 32'(rdyi), 0);
            if (k == 1) begin
                push_beat(1, 16'h5555, 1'b1);
                push_exp(16'h5555, 1'b1, 1);
            end
            @(posedge clk);
        end
        #1 rdyo = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_accept_cycle6", exp_q.size(), 1);
        drain("stall", 100);

        // Move pointer to 3 with a single in2 packet
        push_beat(2, 16'h2222, 1'b1);
        push_exp(16'h2222, 1'b1, 2);
        drain("ptr_to_3", 100);

        // Wrap and bubble: in3 packet with a gap, in0 waits, then ptr=1
        push_beat(3, 16'hD000, 1'b0);
        push_bubble(3);
        push_beat(3, 16'hD001, 1'b0);
        push_beat(3, 16'hD002, 1'b1);
        push_beat(0, 16'hE000, 1'b1);
        push_exp(16'hD000, 1'b0, 3);
        push_exp(16'hD001, 1'b0, 3);
        push_exp(16'hD002, 1'b1, 3);
        push_exp(16'hE000, 1'b1, 0);
        drain("wrap_bubble", 100);

        // Pointer must now be 1: order 1, 2, 0
        push_beat(0, 16'hF000, 1'b1);
        push_beat(1, 16'hF001, 1'b1);
        push_beat(2, 16'hF002, 1'b1);
        push_exp(16'hF001, 1'b1, 1);
        push_exp(16'hF002, 1'b1, 2);
        push_exp(16'hF000, 1'b1, 0);
        drain("ptr_after_wrap", 100);

`ifdef XARB_PKT_CNT_EN
        quiet = 1'b1;
        for (int n = 0; n < 70000; n++) begin
            push_beat(1, 16'(n), 1'b1);
            push_exp(16'(n), 1'b1, 1);
        end
        drain("pkt_bulk", 75000);
        quiet = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("pkt_cnt", 32'(pkt_cnt[i*16 +: 16]), 32'(model_cnt[i] % 65536));
        end
        @(posedge clk);
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("pkt_cnt_reset", 32'(pkt_cnt[i*16 +: 16]), 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
